// File: rtl/ex_alu_stage.sv
// ex_alu_stage -- execute stage of the RV32IM pipeline.
//
// Computes single-cycle ALU/MUL results with one cycle of latency. DIV, DIVU,
// REM and REMU run on a 32-step restoring divider. While the divider runs,
// ex_stall_w is held high and the id_* inputs are ignored.
//
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   id_valid_w       instruction present this cycle
//   id_alu_op_w      operation code (0 ADD .. 15 PASSB)
//   id_use_imm_w     select id_imm_w instead of exe_rb_r as operand B
//   id_imm_w         sign-extended immediate
//   id_rd_index_w    destination register index
//   exe_ra_r         forwarded operand A
//   exe_rb_r         forwarded operand B
//   ex_stall_w       divider busy, upstream must hold
//   ex_valid_r       registered result is real this cycle
//   ex_alu_res_r     registered result
//   ex_rd_index_r    registered destination index (0 for bubbles)
//
// state | meaning
// IDLE  | single-cycle ops issue; a divide op latches operands and starts
// RUN   | one divider step per cycle; outputs are bubbles until step 32
module ex_alu_stage (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        id_valid_w,
  input  logic [3:0]  id_alu_op_w,
  input  logic        id_use_imm_w,
  input  logic [31:0] id_imm_w,
  input  logic [4:0]  id_rd_index_w,
  input  logic [31:0] exe_ra_r,
  input  logic [31:0] exe_rb_r,
  output logic        ex_stall_w,
  output logic        ex_valid_r,
  output logic [31:0] ex_alu_res_r,
  output logic [4:0]  ex_rd_index_r
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLL   = 4'd2;
  localparam logic [3:0] OP_SLT   = 4'd3;
  localparam logic [3:0] OP_SLTU  = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_AND   = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_DIV   = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REM   = 4'd13;
  localparam logic [3:0] OP_REMU  = 4'd14;

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  rd_q, rd_d;

  // divider datapath
  logic [31:0] quo_q, quo_d;        // dividend bits shift out, quotient bits shift in
  logic [31:0] rem_q, rem_d;
  logic [31:0] divisor_q, divisor_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic        signed_q, signed_d;
  logic        is_rem_q, is_rem_d;
  logic        b_zero_q, b_zero_d;
  logic [4:0]  div_rd_q, div_rd_d;

  logic [31:0] op_a, op_b;
  logic [4:0]  shamt;
  logic [31:0] alu_res;
  logic        is_div_op;
  logic        op_signed;
  logic [32:0] rem_shift, rem_diff;
  logic        step_ok;
  logic [31:0] rem_step, quo_step;
  logic [31:0] div_res;

  assign ex_stall_w    = (state_q == S_RUN);
  assign ex_valid_r    = valid_q;
  assign ex_alu_res_r  = res_q;
  assign ex_rd_index_r = rd_q;

  // state and datapath registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      valid_q   <= 1'b0;
      res_q     <= '0;
      rd_q      <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      signed_q  <= 1'b0;
      is_rem_q  <= 1'b0;
      b_zero_q  <= 1'b0;
      div_rd_q  <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      res_q     <= res_d;
      rd_q      <= rd_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      signed_q  <= signed_d;
      is_rem_q  <= is_rem_d;
      b_zero_q  <= b_zero_d;
      div_rd_q  <= div_rd_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (id_valid_w && is_div_op) state_d = S_RUN;
      S_RUN:  if (cnt_q == 5'd31) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // single-cycle ALU
  always_comb begin
    op_a      = exe_ra_r;
    op_b      = id_use_imm_w ? id_imm_w : exe_rb_r;
    shamt     = op_b[4:0];
    is_div_op = (id_alu_op_w >= OP_DIV) && (id_alu_op_w <= OP_REMU);
    op_signed = (id_alu_op_w == OP_DIV) || (id_alu_op_w == OP_REM);
    case (id_alu_op_w)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_SLL:  alu_res = op_a << shamt;
      OP_SLT:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      OP_SLTU: alu_res = {31'd0, op_a < op_b};
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      OP_OR:   alu_res = op_a | op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_MUL:  alu_res = op_a * op_b;
      default: alu_res = op_b;  // PASSB; divide codes never reach the output here
    endcase
  end

  // one restoring step; the last step feeds the result directly
  always_comb begin
    rem_shift = {rem_q, quo_q[31]};
    rem_diff  = rem_shift - {1'b0, divisor_q};
    step_ok   = ~rem_diff[32];
    rem_step  = step_ok ? rem_diff[31:0] : rem_shift[31:0];
    quo_step  = {quo_q[30:0], step_ok};
    // A zero divisor leaves the quotient all ones and the remainder equal to
    // |A|, so only the quotient sign fix-up has to be suppressed.
    if (is_rem_q)
      div_res = (signed_q && sign_a_q) ? -rem_step : rem_step;
    else
      div_res = (signed_q && (sign_a_q != sign_b_q) && !b_zero_q) ? -quo_step : quo_step;
  end

  // output and datapath next values
  always_comb begin
    valid_d   = 1'b0;
    res_d     = '0;
    rd_d      = '0;
    quo_d     = quo_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    signed_d  = signed_q;
    is_rem_d  = is_rem_q;
    b_zero_d  = b_zero_q;
    div_rd_d  = div_rd_q;
    case (state_q)
      S_IDLE: begin
        if (id_valid_w && is_div_op) begin
          sign_a_d  = op_signed && op_a[31];
          sign_b_d  = op_signed && op_b[31];
          quo_d     = (op_signed && op_a[31]) ? -op_a : op_a;
          divisor_d = (op_signed && op_b[31]) ? -op_b : op_b;
          rem_d     = '0;
          cnt_d     = '0;
          signed_d  = op_signed;
          is_rem_d  = (id_alu_op_w == OP_REM) || (id_alu_op_w == OP_REMU);
          b_zero_d  = (op_b == 32'd0);
          div_rd_d  = id_rd_index_w;
        end else if (id_valid_w) begin
          valid_d = 1'b1;
          res_d   = alu_res;
          rd_d    = id_rd_index_w;
        end
      end
      S_RUN: begin
        quo_d = quo_step;
        rem_d = rem_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          valid_d = 1'b1;
          res_d   = div_res;
          rd_d    = div_rd_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ex_alu_stage.sv
module tb_ex_alu_stage;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        id_valid_w;
  logic [3:0]  id_alu_op_w;
  logic        id_use_imm_w;
  logic [31:0] id_imm_w;
  logic [4:0]  id_rd_index_w;
  logic [31:0] exe_ra_r;
  logic [31:0] exe_rb_r;
  logic        ex_stall_w;
  logic        ex_valid_r;
  logic [31:0] ex_alu_res_r;
  logic [4:0]  ex_rd_index_r;

  int total = 0;
  int bad   = 0;

  ex_alu_stage dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .id_valid_w    (id_valid_w),
    .id_alu_op_w   (id_alu_op_w),
    .id_use_imm_w  (id_use_imm_w),
    .id_imm_w      (id_imm_w),
    .id_rd_index_w (id_rd_index_w),
    .exe_ra_r      (exe_ra_r),
    .exe_rb_r      (exe_rb_r),
    .ex_stall_w    (ex_stall_w),
    .ex_valid_r    (ex_valid_r),
    .ex_alu_res_r  (ex_alu_res_r),
    .ex_rd_index_r (ex_rd_index_r)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic use_imm,
                       input logic [31:0] imm, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b);
    id_valid_w    = v;
    id_alu_op_w   = op;
    id_use_imm_w  = use_imm;
    id_imm_w      = imm;
    id_rd_index_w = rd;
    exe_ra_r      = a;
    exe_rb_r      = b;
  endtask

  task automatic idle_in();
    drive(1'b0, 4'd0, 1'b0, 32'd0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic single(input string tag, input logic [3:0] op, input logic use_imm,
                        input logic [31:0] imm, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    drive(1'b1, op, use_imm, imm, rd, a, b);
    step();
    chk({tag, ".res"},   ex_alu_res_r, exp);
    chk({tag, ".valid"}, {31'd0, ex_valid_r}, 32'd1);
    chk({tag, ".rd"},    {27'd0, ex_rd_index_r}, {27'd0, rd});
  endtask

  task automatic divide(input string tag, input logic [3:0] op, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit toggle);
    int n;
    int leak;
    drive(1'b1, op, 1'b0, 32'd0, rd, a, b);
    step();
    idle_in();
    n = 0;
    leak = 0;
    while (ex_stall_w && n < 40) begin
      n++;
      if (ex_valid_r || ex_rd_index_r != 5'd0 || ex_alu_res_r != 32'd0) leak++;
      if (toggle)
        drive(n[0], n[3:0], n[1], $urandom, n[4:0], $urandom, $urandom);
      step();
    end
    idle_in();
    chk({tag, ".stall_cycles"}, n, 32'd32);
    chk({tag, ".bubbles"}, leak, 32'd0);
    chk({tag, ".res"},   ex_alu_res_r, exp);
    chk({tag, ".valid"}, {31'd0, ex_valid_r}, 32'd1);
    chk({tag, ".rd"},    {27'd0, ex_rd_index_r}, {27'd0, rd});
  endtask

  initial begin
    int vcount;
    reset_i = 1'b1;
    idle_in();
    step();
    step();
    chk("rst.valid", {31'd0, ex_valid_r}, 32'd0);
    chk("rst.res",   ex_alu_res_r, 32'd0);
    chk("rst.rd",    {27'd0, ex_rd_index_r}, 32'd0);
    chk("rst.stall", {31'd0, ex_stall_w}, 32'd0);
    reset_i = 1'b0;

    single("add",  4'd0, 1'b0, 32'd0, 5'd3, 32'd5, 32'd7, 32'd12);
    single("sub",  4'd1, 1'b0, 32'd0, 5'd4, 32'd3, 32'd5, 32'hFFFFFFFE);
    single("sra",  4'd7, 1'b1, 32'd4, 5'd6, 32'h80000000, 32'd0, 32'hF8000000);
    single("sltu", 4'd4, 1'b0, 32'd0, 5'd7, 32'd1, 32'hFFFFFFFF, 32'd1);
    single("slt",  4'd3, 1'b0, 32'd0, 5'd8, 32'hFFFFFFFF, 32'd1, 32'd1);
    single("sll",  4'd2, 1'b1, 32'h00000024, 5'd9, 32'h00000003, 32'd0, 32'h00000030);

    idle_in();
    step();
    chk("bub.valid", {31'd0, ex_valid_r}, 32'd0);
    chk("bub.rd",    {27'd0, ex_rd_index_r}, 32'd0);
    chk("bub.res",   ex_alu_res_r, 32'd0);

    single("passb", 4'd15, 1'b1, 32'h12345000, 5'd10, 32'hDEADBEEF, 32'd0, 32'h12345000);
    single("mul",   4'd10, 1'b0, 32'd0, 5'd11, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD);

    divide("div",    4'd11, 5'd5,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0);
    divide("rem",    4'd13, 5'd6,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0);
    divide("divu",   4'd12, 5'd7,  32'd100, 32'd7, 32'd14, 1'b0);
    divide("remu",   4'd14, 5'd8,  32'd100, 32'd7, 32'd2, 1'b0);
    divide("divu0",  4'd12, 5'd9,  32'd9, 32'd0, 32'hFFFFFFFF, 1'b0);
    divide("rem0",   4'd13, 5'd10, 32'd9, 32'd0, 32'd9, 1'b0);
    divide("divneg0",4'd11, 5'd11, 32'hFFFFFFF7, 32'd0, 32'hFFFFFFFF, 1'b0);
    divide("divovf", 4'd11, 5'd12, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
    divide("removf", 4'd13, 5'd13, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0);
    divide("divtgl", 4'd11, 5'd14, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 1'b1);

    // the cycle after a divide result is a bubble
    step();
    chk("postdiv.valid", {31'd0, ex_valid_r}, 32'd0);

    // reset in the middle of a divide
    drive(1'b1, 4'd12, 1'b0, 32'd0, 5'd15, 32'd1000, 32'd3);
    step();
    idle_in();
    for (int i = 0; i < 9; i++) step();
    chk("mid.stall_before", {31'd0, ex_stall_w}, 32'd1);
    reset_i = 1'b1;
    step();
    chk("mid.valid", {31'd0, ex_valid_r}, 32'd0);
    chk("mid.res",   ex_alu_res_r, 32'd0);
    chk("mid.rd",    {27'd0, ex_rd_index_r}, 32'd0);
    chk("mid.stall", {31'd0, ex_stall_w}, 32'd0);
    reset_i = 1'b0;
    single("postrst.add", 4'd0, 1'b0, 32'd0, 5'd1, 32'd1, 32'd1, 32'd2);
    idle_in();
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ex_valid_r || ex_stall_w) vcount++;
    end
    chk("postrst.no_stale", vcount, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
